// File: rtl/rsc_pkg.sv
// Shared types and constants for the ROM-to-RAM scrambling copy engine.
package rsc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StWrRel,
    StDone
  } state_e;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_ILV  = 2'd1;
  localparam logic [1:0] MODE_REV  = 2'd2;
  localparam logic [1:0] MODE_DILV = 2'd3;

endpackage

// File: rtl/bit_permute.sv
// Combinational bit permutation: pass, interleave, bit-reverse or de-interleave.
module bit_permute
  import rsc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] ilv;
  logic [WIDTH-1:0] dilv;
  logic [WIDTH-1:0] rev;

  // Interleave alternates bits taken from the low half and the high half of the input.
  for (genvar k = 0; k < WIDTH / 2; k++) begin : g_pair
    assign ilv[WIDTH-1-2*k]  = in[k];
    assign ilv[WIDTH-2-2*k]  = in[WIDTH-1-k];
    assign dilv[k]           = in[WIDTH-1-2*k];
    assign dilv[WIDTH-1-k]   = in[WIDTH-2-2*k];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign rev[i] = in[WIDTH-1-i];
  end

  always_comb begin
    out = in;
    unique case (mode)
      MODE_PASS: out = in;
      MODE_ILV:  out = ilv;
      MODE_REV:  out = rev;
      MODE_DILV: out = dilv;
      default:   out = in;
    endcase
  end

endmodule

// File: rtl/rom_scramble_copy.sv
// Copies a block of ROM words through a bit permutation into RAM, one word per ROM_LAT+2 cycles.
module rom_scramble_copy
  import rsc_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 5,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [DEPTH-1:0] src_base,
  input  logic [DEPTH-1:0] dst_base,
  input  logic [DEPTH:0]   count,
  output logic             busy,
  output logic             done,
  output logic [DEPTH:0]   words_done,
  output logic [DEPTH-1:0] rom_addr,
  output logic             rom_cs_n,
  output logic             rom_oe_n,
  input  logic [WIDTH-1:0] rom_data,
  output logic [DEPTH-1:0] ram_addr,
  output logic             ram_cs_n,
  output logic             ram_oe_n,
  output logic             ram_ws_n,
  output logic [WIDTH-1:0] ram_wdata
);

  localparam int unsigned      LatW    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [LatW-1:0]  LatLast = LatW'(ROM_LAT - 1);
  localparam logic [LatW-1:0]  LatOne  = LatW'(1);
  localparam logic [DEPTH-1:0] PtrOne  = DEPTH'(1);
  localparam logic [DEPTH:0]   CntOne  = (DEPTH + 1)'(1);

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [DEPTH-1:0] src_q, dst_q;
  logic [DEPTH:0]   count_q, words_done_q;
  logic [LatW-1:0]  lat_q;
  logic             busy_q, done_q;
  logic [DEPTH-1:0] rom_addr_q, ram_addr_q;
  logic             rom_cs_n_q, rom_oe_n_q, ram_cs_n_q, ram_ws_n_q;
  logic [WIDTH-1:0] ram_wdata_q;
  logic [WIDTH-1:0] perm_data;
  logic [DEPTH:0]   words_done_inc;

  assign words_done_inc = words_done_q + CntOne;

  bit_permute #(
    .WIDTH(WIDTH)
  ) u_bit_permute (
    .mode(mode_q),
    .in  (rom_data),
    .out (perm_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mode_q       <= MODE_PASS;
      src_q        <= '0;
      dst_q        <= '0;
      count_q      <= '0;
      words_done_q <= '0;
      lat_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rom_addr_q   <= '0;
      ram_addr_q   <= '0;
      rom_cs_n_q   <= 1'b1;
      rom_oe_n_q   <= 1'b1;
      ram_cs_n_q   <= 1'b1;
      ram_ws_n_q   <= 1'b1;
      ram_wdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mode_q       <= mode;
            src_q        <= src_base;
            dst_q        <= dst_base;
            count_q      <= count;
            words_done_q <= '0;
            busy_q       <= 1'b1;
            if (count == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StRd;
              lat_q      <= '0;
              rom_addr_q <= src_base;
              rom_cs_n_q <= 1'b0;
              rom_oe_n_q <= 1'b0;
            end
          end
        end
        StRd: begin
          if (lat_q == LatLast) begin
            state_q     <= StWr;
            ram_wdata_q <= perm_data;
            ram_addr_q  <= dst_q;
            rom_cs_n_q  <= 1'b1;
            rom_oe_n_q  <= 1'b1;
            ram_cs_n_q  <= 1'b0;
            ram_ws_n_q  <= 1'b0;
          end else begin
            lat_q <= lat_q + LatOne;
          end
        end
        StWr: begin
          // Release WS while CS, address and data hold for one more cycle.
          state_q    <= StWrRel;
          ram_ws_n_q <= 1'b1;
        end
        StWrRel: begin
          words_done_q <= words_done_inc;
          src_q        <= src_q + PtrOne;
          dst_q        <= dst_q + PtrOne;
          ram_cs_n_q   <= 1'b1;
          if (words_done_inc == count_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q    <= StRd;
            lat_q      <= '0;
            rom_addr_q <= src_q + PtrOne;
            rom_cs_n_q <= 1'b0;
            rom_oe_n_q <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign words_done = words_done_q;
  assign rom_addr   = rom_addr_q;
  assign rom_cs_n   = rom_cs_n_q;
  assign rom_oe_n   = rom_oe_n_q;
  assign ram_addr   = ram_addr_q;
  assign ram_cs_n   = ram_cs_n_q;
  assign ram_oe_n   = 1'b1;
  assign ram_ws_n   = ram_ws_n_q;
  assign ram_wdata  = ram_wdata_q;

endmodule

// File: doc/rom_scramble_copy.md
# rom_scramble_copy

Hardware DMA-style copier that streams a block of words out of the `rom` array, passes each word through a selectable bit permutation, and writes the result into the `regfile` RAM. It moves the ROM-read / scramble / RAM-write sequence into a synthesizable, parametrised engine with a start/done handshake. The engine sits between a controller and the two memories and drives both memories' active-low CS/OE/WS strobes directly.

## Interface
- `WIDTH`, 8: data width in bits; must be even.
- `DEPTH`, 5: address width in bits; each memory holds 2**DEPTH words.
- `ROM_LAT`, 1: cycles from ROM address/strobe valid to data valid; must be at least 1.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `mode` in 2: permutation select, latched at start. 0 = pass, 1 = interleave, 2 = bit-reverse, 3 = de-interleave.
- `src_base` in DEPTH: first ROM address, latched at start.
- `dst_base` in DEPTH: first RAM address, latched at start.
- `count` in DEPTH+1: number of words to copy, 0..2**DEPTH, latched at start.
- `busy` out 1: high from the cycle after start is accepted until DONE completes.
- `done` out 1: one-cycle pulse at completion.
- `words_done` out DEPTH+1: number of words written so far in the current or last job.
- `rom_addr` out DEPTH, `rom_cs_n` out 1, `rom_oe_n` out 1, `rom_data` in WIDTH: ROM port.
- `ram_addr` out DEPTH, `ram_cs_n` out 1, `ram_oe_n` out 1, `ram_ws_n` out 1, `ram_wdata` out WIDTH: RAM port.
- `ram_oe_n` is held high. The RAM is write-only from this block.

## Operation
- States: IDLE, RD, WR, WR_REL, DONE.
- IDLE:
  - All strobes are high.
  - `start`=1 latches `mode`, the bases and `count`, and clears `words_done`.
  - If `count`=0, go to DONE. Otherwise go to RD.
- RD:
  - `rom_addr` = src pointer. `rom_cs_n`=0, `rom_oe_n`=0.
  - Stays in RD for ROM_LAT cycles.
  - On the last of those cycles, capture perm(`rom_data`) into the write register, then go to WR.
- WR:
  - `ram_cs_n`=0. `ram_ws_n`=0 for exactly one cycle.
  - `ram_addr` = dst pointer. `ram_wdata` = write register.
  - ROM strobes are high.
- WR_REL:
  - `ram_ws_n`=1. `ram_cs_n`, `ram_addr` and `ram_wdata` hold their WR values, which gives hold time after the rising edge of WS.
  - Increment `words_done` and both pointers.
  - If `words_done`+1 equals `count`, go to DONE. Otherwise go to RD.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Pointers are DEPTH bits wide and wrap modulo 2**DEPTH; no error is raised on wrap.
- Permutations, for k = 0..WIDTH/2-1:
  - Interleave: out[W-1-2k] = in[k] and out[W-2-2k] = in[W-1-k].
  - De-interleave is its exact inverse.
  - Bit-reverse: out[i] = in[W-1-i].
- `start` while `busy` is ignored. The latched parameters are never altered mid-job.
- Reset mid-job:
  - Immediate return to IDLE.
  - All strobes go high asynchronously.
  - A partial write (WS low) is cut short; that RAM word is undefined.

## Timing
- Reset values: `busy`=0, `done`=0, `words_done`=0, all `*_cs_n`/`*_oe_n`/`ram_ws_n`=1, addresses=0, `ram_wdata`=0.
- Per word: ROM_LAT+2 cycles.
- Job of N≥1 words: start accepted at edge 0; `done` is high in cycle N·(ROM_LAT+2)+1.
- N=0: `done` is high in cycle 1 and no strobe toggles.
- `start` in the same cycle as `done`: ignored, because the FSM is not yet in IDLE.
- `start` is honoured in the cycle after `done` drops.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Package `rsc_pkg` holds:
  - the state enum;
  - the mode constants: MODE_PASS=0, MODE_ILV=1, MODE_REV=2, MODE_DILV=3.
- Sub-module `bit_permute` (parameter WIDTH; inputs `mode` and `in`; output `out`).
  - Purely combinational, built from generate loops.
  - Instantiated once on the ROM data path, before the capture register.
- The top level holds the FSM, the latency counter, the two pointers and `words_done`.

## Test plan
- Reset: pulse `rst_n` low mid-RD.
  - All strobes are high within the same cycle. `busy`=0, `words_done`=0.
- Interleave, 8-bit:
  - ROM[4]=0xA5, src=4, dst=0, count=1, mode=1.
  - Expect RAM[0]=0xCC, `done` in cycle 4 (ROM_LAT=1), exactly one WS low pulse.
- Permutation modes on ROM word 0x02:
  - mode 1 writes 0x20;
  - mode 2 writes 0x40;
  - mode 3 applied to 0x20 writes 0x02;
  - mode 0 writes 0x02.
- Full copy with wrap-around:
  - src=4, dst=10, count=27, ROM_LAT=3, ROM loaded with an incrementing pattern.
  - Expect RAM[(10+i) mod 32] = perm(ROM[(4+i) mod 32]).
  - `done` at cycle 136; `words_done`=27.
- Edge requests:
  - count=0 gives `done` at cycle 1 with no strobe activity.
  - A `start` pulse while `busy` does not change the job or restart it.
- Back-to-back jobs:
  - Issue the second `start` in the cycle after `done`.
  - The second job runs with its own parameters; `words_done` restarts at 0.
